vx_smem_responder: RTL and testbench

- Banked on-chip scratchpad that sits on the responder side of the per-lane dcache core request/response interface. It serves the LSU directly in place of the dcache.
- Accepts up to NUM_REQS lane requests per cycle, arbitrates bank conflicts, performs byte-enabled writes and registered reads, and returns read data as a lane-masked response beat that carries one tag.
- Partial masks are legal. The requester tracks the lanes it still expects per tag.

---
 rtl/vx_smem_pkg.sv | 28 ++
 rtl/vx_smem_bank.sv | 25 ++
 rtl/vx_smem_responder.sv | 149 ++++++++++++++
 tb/tb_vx_smem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_smem_pkg.sv
// vx_smem_pkg: shared constants, address helpers and the per-lane request struct for the scratchpad responder.
package vx_smem_pkg;

    localparam int SMEM_NUM_BANKS  = 4;
    localparam int SMEM_BANK_WORDS = 256;
    localparam int SMEM_TAG_WIDTH  = 8;
    localparam int BANK_SEL_BITS   = $clog2(SMEM_NUM_BANKS);
    localparam int WORD_SEL_BITS   = $clog2(SMEM_BANK_WORDS);

    typedef struct packed {
        logic                      rw;
        logic [29:0]               addr;
        logic [3:0]                byteen;
        logic [31:0]               data;
        logic [SMEM_TAG_WIDTH-1:0] tag;
    } smem_req_t;

    // Word-interleaved map: low bits pick the bank, the next bits pick the word, the rest alias.
    function automatic logic [29:0] get_bank(input logic [29:0] addr, input int bsel = BANK_SEL_BITS);
        return addr & ((30'(1) << bsel) - 30'(1));
    endfunction

    function automatic logic [29:0] get_word(input logic [29:0] addr, input int bsel = BANK_SEL_BITS,
                                             input int wsel = WORD_SEL_BITS);
        return (addr >> bsel) & ((30'(1) << wsel) - 30'(1));
    endfunction

endpackage

// File: rtl/vx_smem_bank.sv
// vx_smem_bank: one scratchpad bank with a byte-enabled write port and a one-cycle registered read.
module vx_smem_bank #(
    parameter int WORDS = 256
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic                     i_rd_en,
    input  logic [$clog2(WORDS)-1:0] i_addr,
    input  logic [3:0]               i_byteen,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);

    logic [3:0][7:0] r_mem [WORDS];
    logic [31:0]     r_rdata;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (i_wr_en && i_byteen[k]) r_mem[i_addr][k] <= i_wdata[k*8 +: 8];
        if (i_rd_en) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vx_smem_responder.sv
// vx_smem_responder: banked scratchpad answering per-lane requests with one-tag, lane-masked response beats.
// Define VX_SMEM_BROADCAST_EN to grant same-word reads in one bank together in a single beat.
module vx_smem_responder
    import vx_smem_pkg::*;
#(
    parameter int NUM_REQS   = 4,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_WORDS = 256,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           i_req_valid,
    input  logic [NUM_REQS-1:0]           i_req_rw,
    input  logic [NUM_REQS*30-1:0]        i_req_addr,
    input  logic [NUM_REQS*4-1:0]         i_req_byteen,
    input  logic [NUM_REQS*32-1:0]        i_req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0] i_req_tag,
    output logic [NUM_REQS-1:0]           o_req_ready,
    output logic [NUM_REQS-1:0]           o_rsp_valid,
    output logic [NUM_REQS*32-1:0]        o_rsp_data,
    output logic [TAG_WIDTH-1:0]          o_rsp_tag,
    input  logic                          i_rsp_ready
);

    localparam int BSEL = $clog2(NUM_BANKS);
    localparam int BIDX = (BSEL > 0) ? BSEL : 1;
    localparam int WSEL = $clog2(BANK_WORDS);

    smem_req_t                 w_req      [NUM_REQS];
    logic [BIDX-1:0]           w_bank     [NUM_REQS];
    logic [WSEL-1:0]           w_word     [NUM_REQS];
    logic                      w_lead_rw;
    logic [SMEM_TAG_WIDTH-1:0] w_lead_tag;
    logic [NUM_REQS-1:0]       w_elig;
    logic [NUM_REQS-1:0]       w_first;
    logic [NUM_REQS-1:0]       w_grant;
    logic [NUM_REQS-1:0]       w_rd_fire;
    logic                      w_stage_en;
    logic [NUM_BANKS-1:0]      w_bwe;
    logic [NUM_BANKS-1:0]      w_bre;
    logic [WSEL-1:0]           w_baddr    [NUM_BANKS];
    logic [3:0]                w_bbe      [NUM_BANKS];
    logic [31:0]               w_bwd      [NUM_BANKS];
    logic [31:0]               w_brd      [NUM_BANKS];
    logic [NUM_REQS-1:0]       r_rsp_valid;
    logic [TAG_WIDTH-1:0]      r_rsp_tag;
    logic [BIDX-1:0]           r_rsp_bank [NUM_REQS];

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
        assign w_req[i] = '{rw:     i_req_rw[i],
                            addr:   i_req_addr[i*30 +: 30],
                            byteen: i_req_byteen[i*4 +: 4],
                            data:   i_req_data[i*32 +: 32],
                            tag:    SMEM_TAG_WIDTH'(i_req_tag[i*TAG_WIDTH +: TAG_WIDTH])};
        assign w_bank[i] = BIDX'(get_bank(w_req[i].addr, BSEL));
        assign w_word[i] = WSEL'(get_word(w_req[i].addr, BSEL, WSEL));
        assign o_rsp_data[i*32 +: 32] = r_rsp_valid[i] ? w_brd[r_rsp_bank[i]] : 32'd0;
    end

    // Leader is the lowest valid lane; its tag and direction define this cycle's candidates.
    always_comb begin
        w_lead_rw  = 1'b0;
        w_lead_tag = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--)
            if (i_req_valid[i]) begin
                w_lead_rw  = w_req[i].rw;
                w_lead_tag = w_req[i].tag;
            end
    end

    always_comb begin
        w_elig  = '0;
        w_first = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_elig[i]  = i_req_valid[i] && w_req[i].tag == w_lead_tag && w_req[i].rw == w_lead_rw;
            w_first[i] = w_elig[i];
            for (int j = 0; j < i; j++)
                if (w_elig[j] && w_bank[j] == w_bank[i]) w_first[i] = 1'b0;
        end
    end

`ifdef VX_SMEM_BROADCAST_EN
    // A read riding on the bank owner's word shares the owner's bank access.
    always_comb begin
        w_grant = w_first;
        for (int i = 0; i < NUM_REQS; i++)
            for (int j = 0; j < i; j++)
                if (w_first[j] && w_elig[i] && !w_lead_rw && w_bank[j] == w_bank[i] && w_word[j] == w_word[i])
                    w_grant[i] = 1'b1;
    end
`else
    assign w_grant = w_first;
`endif

    assign w_stage_en  = ~|r_rsp_valid | i_rsp_ready;
    assign o_req_ready = reset ? '0 : (w_grant & {NUM_REQS{w_stage_en}});
    assign w_rd_fire   = o_req_ready & ~i_req_rw;

    // Descending scan leaves the lowest fired lane driving each bank port.
    always_comb begin
        w_bwe = '0;
        w_bre = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_baddr[b] = '0;
            w_bbe[b]   = '0;
            w_bwd[b]   = '0;
        end
        for (int i = NUM_REQS - 1; i >= 0; i--)
            if (o_req_ready[i]) begin
                w_bwe[w_bank[i]]   = w_req[i].rw;
                w_bre[w_bank[i]]   = ~w_req[i].rw;
                w_baddr[w_bank[i]] = w_word[i];
                w_bbe[w_bank[i]]   = w_req[i].byteen;
                w_bwd[w_bank[i]]   = w_req[i].data;
            end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        vx_smem_bank #(.WORDS(BANK_WORDS)) u_bank (
            .clk      (clk),
            .i_wr_en  (w_bwe[b]),
            .i_rd_en  (w_bre[b]),
            .i_addr   (w_baddr[b]),
            .i_byteen (w_bbe[b]),
            .i_wdata  (w_bwd[b]),
            .o_rdata  (w_brd[b])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= '0;
            r_rsp_tag   <= '0;
        end else if (w_stage_en) begin
            r_rsp_valid <= w_rd_fire;
            if (|w_rd_fire) r_rsp_tag <= TAG_WIDTH'(w_lead_tag);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++)
            if (w_rd_fire[i]) r_rsp_bank[i] <= w_bank[i];
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_tag   = r_rsp_tag;

endmodule

// File: tb/tb_vx_smem_responder.sv
// tb_vx_smem_responder: randomized and directed checks of the scratchpad responder against a flat-memory model.
module tb_vx_smem_responder;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    vld = '0;
    logic [3:0]    rw = '0;
    logic [29:0]   ad [4];
    logic [3:0]    be [4];
    logic [31:0]   wd [4];
    logic [7:0]    tg [4];
    logic          rsp_ready = 1'b1;
    logic [119:0]  req_addr;
    logic [15:0]   req_byteen;
    logic [127:0]  req_data;
    logic [31:0]   req_tag;
    logic [3:0]    req_ready;
    logic [3:0]    rsp_valid;
    logic [127:0]  rsp_data;
    logic [7:0]    rsp_tag;

    logic [31:0]   mem_m [1024];
    logic [3:0]    m_valid = '0;
    logic [7:0]    m_tag = '0;
    logic [31:0]   m_data [4];
    logic [3:0]    fired;
    int            n_chk = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_addr[g*30 +: 30]  = ad[g];
        assign req_byteen[g*4 +: 4]  = be[g];
        assign req_data[g*32 +: 32]  = wd[g];
        assign req_tag[g*8 +: 8]     = tg[g];
    end

    vx_smem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (vld),
        .i_req_rw     (rw),
        .i_req_addr   (req_addr),
        .i_req_byteen (req_byteen),
        .i_req_data   (req_data),
        .i_req_tag    (req_tag),
        .o_req_ready  (req_ready),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_rsp_tag    (rsp_tag),
        .i_rsp_ready  (rsp_ready)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic w, input logic [29:0] a, input logic [3:0] e,
                            input logic [31:0] d, input logic [7:0] t);
        vld[i] = 1'b1;
        rw[i]  = w;
        ad[i]  = a;
        be[i]  = e;
        wd[i]  = d;
        tg[i]  = t;
    endtask

    // Spec-level arbitration: leader picks tag/direction, each bank serves its lowest matching lane.
    function automatic logic [3:0] model_grant(output int lead);
        int owner [4];
        logic [3:0] g;
        g = '0;
        lead = -1;
        for (int b = 0; b < 4; b++) owner[b] = -1;
        for (int i = 0; i < 4; i++) if (vld[i] && lead < 0) lead = i;
        if (lead < 0) return g;
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && tg[i] == tg[lead] && rw[i] == rw[lead]) begin
                if (owner[ad[i] % 4] < 0) begin
                    owner[ad[i] % 4] = i;
                    g[i] = 1'b1;
                end
`ifdef VX_SMEM_BROADCAST_EN
                else if (!rw[lead] && (ad[i] / 4) % 256 == (ad[owner[ad[i] % 4]] / 4) % 256) g[i] = 1'b1;
`endif
            end
        end
        return g;
    endfunction

    // One clock: check req_ready, advance the model across the edge, then check the response.
    task automatic step(input logic rdy);
        logic [3:0] g;
        logic [3:0] nv;
        int lead;
        bit en;
        rsp_ready = rdy;
        #1;
        en = (m_valid == 4'b0) || rdy;
        g = model_grant(lead);
        fired = en ? g : 4'b0;
        check("req_ready", req_ready, fired);
        if (en) begin
            nv = '0;
            for (int i = 0; i < 4; i++)
                if (g[i] && rw[i]) begin
                    for (int k = 0; k < 4; k++)
                        if (be[i][k]) mem_m[int'(ad[i] % 1024)][k*8 +: 8] = wd[i][k*8 +: 8];
                end else if (g[i]) begin
                    m_data[i] = mem_m[int'(ad[i] % 1024)];
                    nv[i] = 1'b1;
                end
            if (nv != 4'b0) m_tag = tg[lead];
            m_valid = nv;
        end
        @(negedge clk);
        check("rsp_valid", rsp_valid, m_valid);
        if (m_valid != 4'b0) check("rsp_tag", rsp_tag, m_tag);
        for (int i = 0; i < 4; i++)
            if (m_valid[i]) check("rsp_data", rsp_data[i*32 +: 32], m_data[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 30'(i), 4'hF, 32'd0, 8'd0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", req_ready, 4'b0);
        check("reset_valid", rsp_valid, 4'b0);
        check("reset_tag", rsp_tag, 8'd0);
        check("reset_data", rsp_data[63:0], 64'd0);
        @(negedge clk);
        reset = 1'b0;
        vld = '0;

        for (int w = 0; w < 256; w++) begin
            for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 30'(w * 4 + i), 4'hF, $urandom, 8'd0);
            step(1'b1);
        end
        vld = '0;

        for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 30'(i), 4'hF, 32'hA0 + 32'(i), 8'd5);
        step(1'b1);
        check("disj_wr_fire", fired, 4'hF);
        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 30'(i), 4'hF, 32'd0, 8'd6);
        step(1'b1);
        check("disj_mask", rsp_valid, 4'hF);
        check("disj_tag", rsp_tag, 8'd6);
        for (int i = 0; i < 4; i++) check("disj_data", rsp_data[i*32 +: 32], 32'hA0 + 32'(i));
        vld = '0;

        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 30'(i * 4), 4'hF, 32'd0, 8'd3);
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            check("conf_mask", rsp_valid, 4'b0001 << k);
            check("conf_tag", rsp_tag, 8'd3);
            vld &= ~fired;
        end
        check("conf_drained", vld, 4'b0);

        set_lane(0, 1'b1, 30'd7, 4'hF, 32'h11223344, 8'd0);
        step(1'b1);
        set_lane(0, 1'b1, 30'd7, 4'b0010, 32'h0000AA00, 8'd0);
        step(1'b1);
        set_lane(0, 1'b0, 30'd7, 4'hF, 32'd0, 8'd0);
        step(1'b1);
        check("byteen_data", rsp_data[31:0], 32'h1122AA44);

        set_lane(0, 1'b1, 30'd40, 4'hF, 32'hDEADBEEF, 8'd0);
        step(1'b1);
        set_lane(0, 1'b0, 30'd40 + 30'd5120, 4'hF, 32'd0, 8'd0);
        step(1'b1);
        check("wrap_raw_data", rsp_data[31:0], 32'hDEADBEEF);

        set_lane(0, 1'b0, 30'd1, 4'hF, 32'd0, 8'd7);
        step(1'b1);
        vld = '0;
        set_lane(1, 1'b0, 30'd2, 4'hF, 32'd0, 8'd8);
        repeat (3) begin
            step(1'b0);
            check("bp_valid", rsp_valid, 4'b0001);
            check("bp_tag", rsp_tag, 8'd7);
            check("bp_data", rsp_data[31:0], 32'hA1);
        end
        step(1'b1);
        check("bp_resume_mask", rsp_valid, 4'b0010);
        check("bp_resume_tag", rsp_tag, 8'd8);
        check("bp_resume_data", rsp_data[63:32], 32'hA2);
        vld = '0;

        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 30'(i), 4'hF, 32'd0, (i < 2) ? 8'd1 : 8'd2);
        step(1'b1);
        check("mixed_mask0", rsp_valid, 4'b0011);
        check("mixed_tag0", rsp_tag, 8'd1);
        vld &= ~fired;
        step(1'b1);
        check("mixed_mask1", rsp_valid, 4'b1100);
        check("mixed_tag1", rsp_tag, 8'd2);
        vld &= ~fired;

        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 30'd9, 4'hF, 32'd0, 8'd4);
        n = 0;
        while (vld != 4'b0 && n < 8) begin
            step(1'b1);
            vld &= ~fired;
            n++;
        end
`ifdef VX_SMEM_BROADCAST_EN
        check("bcast_beats", 64'(n), 64'd1);
`else
        check("bcast_beats", 64'(n), 64'd4);
`endif
        check("bcast_drained", vld, 4'b0);

        step(1'b1);
        check("idle_valid", rsp_valid, 4'b0);

        set_lane(0, 1'b0, 30'd3, 4'hF, 32'd0, 8'd9);
        step(1'b1);
        vld = '0;
        step(1'b0);
        set_lane(2, 1'b0, 30'd6, 4'hF, 32'd0, 8'd9);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("midreset_valid", rsp_valid, 4'b0);
        check("midreset_ready", req_ready, 4'b0);
        reset = 1'b0;
        m_valid = '0;
        m_tag = '0;
        vld = '0;
        @(negedge clk);

        repeat (400) begin
            for (int i = 0; i < 4; i++) begin
                vld[i] = ($urandom % 4) != 0;
                rw[i]  = $urandom % 2;
                ad[i]  = 30'($urandom);
                be[i]  = 4'($urandom);
                wd[i]  = $urandom;
                tg[i]  = 8'($urandom_range(0, 2));
            end
            step(($urandom % 4) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
